// File: rtl/brj_ctrl_if.sv
// brj_ctrl_if: ID-stage branch/jump strobes, operand and fetch redirect bundle
interface brj_ctrl_if;
  logic        id_valid;
  logic        beqz, bnez, bltz, bgez, j, jr, jal, jalr;
  logic [15:0] rs;
  logic        rs_ready;
  logic [15:0] target_imm;
  logic [15:0] target_reg;
  logic        ex_stall;
  logic        fetch_ack;
  logic        stall_id;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        flush_if;
  logic        link_we;
  logic        wait_err;
  logic [15:0] brj_cnt;
  logic [15:0] taken_cnt;
  modport master (
    output id_valid, beqz, bnez, bltz, bgez, j, jr, jal, jalr, rs, rs_ready,
           target_imm, target_reg, ex_stall, fetch_ack,
    input  stall_id, redirect_valid, redirect_pc, flush_if, link_we, wait_err,
           brj_cnt, taken_cnt
  );
  modport slave (
    input  id_valid, beqz, bnez, bltz, bgez, j, jr, jal, jalr, rs, rs_ready,
           target_imm, target_reg, ex_stall, fetch_ack,
    output stall_id, redirect_valid, redirect_pc, flush_if, link_we, wait_err,
           brj_cnt, taken_cnt
  );
endinterface

// File: rtl/brj_ctrl.sv
// brj_ctrl: ID-stage branch/jump resolver with held fetch redirect; BRJ_STATS_EN enables brj_cnt/taken_cnt
module brj_ctrl #(
  parameter int RS_WAIT_MAX = 15
) (
  input logic       clk,
  input logic       rst,
  brj_ctrl_if.slave b
);
  typedef enum logic [1:0] {IDLE, WAIT_RS, REDIRECT} st_t;
  st_t         st_q, st_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] pc_q, pc_d;
  logic        err_q, err_d;
  logic        brj, needs_rs, zero, neg, taken, qual, decide, stall;
  logic [15:0] tgt;
  assign brj      = b.beqz | b.bnez | b.bltz | b.bgez | b.j | b.jr | b.jal | b.jalr;
  assign needs_rs = b.beqz | b.bnez | b.bltz | b.bgez | b.jr | b.jalr;
  assign zero     = b.rs == 16'h0000;
  assign neg      = b.rs[15];
  assign taken    = (b.jalr | b.jr | b.jal | b.j) ? 1'b1 :
                    b.bgez ? ~neg : b.bltz ? neg : b.bnez ? ~zero : zero;
  assign tgt      = (b.jalr | b.jr) ? b.target_reg : b.target_imm;
  assign qual     = b.id_valid & brj & ~b.ex_stall;
  // next state, wait counting and decision-cycle strobes
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    pc_d   = pc_q;
    err_d  = err_q;
    decide = 1'b0;
    stall  = 1'b0;
    case (st_q)
      IDLE: begin
        if (qual && needs_rs && !b.rs_ready) begin
          st_d  = WAIT_RS;
          cnt_d = 8'd0;
          stall = 1'b1;
        end else decide = qual;
      end
      WAIT_RS: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        if (!b.id_valid) st_d = IDLE;
        else if (b.rs_ready && !b.ex_stall) decide = 1'b1;
        else begin
          stall = 1'b1;
          err_d = err_q | (cnt_q >= 8'(RS_WAIT_MAX));
        end
      end
      REDIRECT: begin
        stall = 1'b1;
        if (b.fetch_ack) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
    if (decide) begin
      st_d = taken ? REDIRECT : IDLE;
      pc_d = taken ? {tgt[15:1], 1'b0} : pc_q;
    end
  end
  // state, held redirect target and sticky wait error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= IDLE;
      cnt_q <= 8'd0;
      pc_q  <= 16'h0000;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end
  assign b.stall_id       = stall;
  assign b.redirect_valid = st_q == REDIRECT;
  assign b.flush_if       = st_q == REDIRECT;
  assign b.redirect_pc    = pc_q;
  assign b.link_we        = decide & (b.jalr | (b.jal & ~b.jr));
  assign b.wait_err       = err_q;
`ifdef BRJ_STATS_EN
  logic [15:0] bc_q, bc_d, tc_q, tc_d;
  assign bc_d = decide ? bc_q + 16'd1 : bc_q;
  assign tc_d = (decide & taken) ? tc_q + 16'd1 : tc_q;
  // resolved and taken counters, wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bc_q <= 16'h0000;
      tc_q <= 16'h0000;
    end else begin
      bc_q <= bc_d;
      tc_q <= tc_d;
    end
  end
  assign b.brj_cnt   = bc_q;
  assign b.taken_cnt = tc_q;
`else
  assign b.brj_cnt   = 16'h0000;
  assign b.taken_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_brj_ctrl.sv
// tb_brj_ctrl: directed checks of brj_ctrl decisions, waits, redirect hold and reset
module tb_brj_ctrl;
  localparam logic [7:0] BEQZ = 8'h01, BNEZ = 8'h02, BLTZ = 8'h04, BGEZ = 8'h08,
                         J = 8'h10, JAL = 8'h20, JR = 8'h40, JALR = 8'h80;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  brj_ctrl_if b ();
  brj_ctrl #(.RS_WAIT_MAX(2)) dut (.clk(clk), .rst(rst), .b(b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    b.id_valid = 1'b0;
    {b.jalr, b.jr, b.jal, b.j, b.bgez, b.bltz, b.bnez, b.beqz} = 8'h00;
    b.rs_ready = 1'b0;
    b.ex_stall = 1'b0;
    b.fetch_ack = 1'b0;
  endtask
  task automatic drive(input logic [7:0] s, input logic [15:0] r, input logic rdy,
                       input logic [15:0] imm, input logic [15:0] rg);
    b.id_valid = 1'b1;
    {b.jalr, b.jr, b.jal, b.j, b.bgez, b.bltz, b.bnez, b.beqz} = s;
    b.rs = r;
    b.rs_ready = rdy;
    b.target_imm = imm;
    b.target_reg = rg;
  endtask
  task automatic go(input string tag, input logic [7:0] s, input logic [15:0] r,
                    input logic [15:0] imm, input logic [15:0] rg,
                    input logic exp_t, input logic [15:0] exp_pc);
    drive(s, r, 1'b1, imm, rg);
    @(negedge clk);
    chk({tag, " stall"}, b.stall_id, 0);
    tick();
    clr();
    chk({tag, " rv"}, b.redirect_valid, exp_t);
    if (exp_t) begin
      chk({tag, " pc"}, b.redirect_pc, exp_pc);
      b.fetch_ack = 1'b1;
      tick();
      b.fetch_ack = 1'b0;
      chk({tag, " exit"}, b.redirect_valid, 0);
    end else chk({tag, " nostall"}, b.stall_id, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    clr();
    b.rs = 16'h0000;
    b.target_imm = 16'h0000;
    b.target_reg = 16'h0000;
    #12;
    chk("rst stall", b.stall_id, 0);
    chk("rst rv", b.redirect_valid, 0);
    chk("rst pc", b.redirect_pc, 0);
    chk("rst flush", b.flush_if, 0);
    chk("rst err", b.wait_err, 0);
    chk("rst bcnt", b.brj_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    drive(BEQZ, 16'h0000, 1'b1, 16'h0123, 16'h0000);
    @(negedge clk);
    chk("beqz stall", b.stall_id, 0);
    chk("beqz link", b.link_we, 0);
    chk("beqz rv comb", b.redirect_valid, 0);
    tick();
    clr();
    chk("beqz rv", b.redirect_valid, 1);
    chk("beqz pc", b.redirect_pc, 16'h0122);
    chk("beqz flush", b.flush_if, 1);
    chk("beqz rstall", b.stall_id, 1);
    b.fetch_ack = 1'b1;
    tick();
    b.fetch_ack = 1'b0;
    chk("beqz flush1", b.flush_if, 0);
    chk("beqz rv off", b.redirect_valid, 0);
    go("bltz", BLTZ, 16'h8000, 16'h0456, 16'h0000, 1'b1, 16'h0456);
    go("bgez", BGEZ, 16'h0000, 16'h0789, 16'h0000, 1'b1, 16'h0788);
    go("bnez", BNEZ, 16'h0000, 16'h0456, 16'h0000, 1'b0, 16'h0000);
    go("bgezneg", BGEZ, 16'hFFFF, 16'h0456, 16'h0000, 1'b0, 16'h0000);
    go("prio", BNEZ | BEQZ, 16'h0000, 16'h0456, 16'h0000, 1'b0, 16'h0000);
    go("jprio", J | BEQZ, 16'h0005, 16'h0AB1, 16'h0CD3, 1'b1, 16'h0AB0);
    go("jr", JR, 16'h0005, 16'h0AB1, 16'h1235, 1'b1, 16'h1234);
    drive(BEQZ, 16'h0000, 1'b1, 16'h0100, 16'h0000);
    b.ex_stall = 1'b1;
    tick();
    clr();
    chk("exstall rv", b.redirect_valid, 0);
    drive(JALR, 16'h0010, 1'b0, 16'h0000, 16'h2001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("jalr wstall", b.stall_id, 1);
      chk("jalr wlink", b.link_we, 0);
      tick();
    end
    b.rs_ready = 1'b1;
    @(negedge clk);
    chk("jalr rstall", b.stall_id, 0);
    chk("jalr link", b.link_we, 1);
    tick();
    clr();
    chk("jalr rv", b.redirect_valid, 1);
    chk("jalr pc", b.redirect_pc, 16'h2000);
    chk("jalr err", b.wait_err, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold pc", b.redirect_pc, 16'h2000);
      chk("hold rv", b.redirect_valid, 1);
      tick();
    end
    b.fetch_ack = 1'b1;
    @(negedge clk);
    chk("ack rv", b.redirect_valid, 1);
    tick();
    b.fetch_ack = 1'b0;
    chk("ack exit", b.redirect_valid, 0);
    chk("ack stall", b.stall_id, 0);
    drive(BNEZ, 16'h0001, 1'b0, 16'h0300, 16'h0000);
    tick();
    b.id_valid = 1'b0;
    tick();
    clr();
    @(negedge clk);
    chk("drop stall", b.stall_id, 0);
    tick();
    chk("drop rv", b.redirect_valid, 0);
    drive(BLTZ, 16'h8000, 1'b0, 16'h0302, 16'h0000);
    for (int i = 0; i < 4; i++) tick();
    chk("werr set", b.wait_err, 1);
    b.rs_ready = 1'b1;
    tick();
    clr();
    chk("werr rv", b.redirect_valid, 1);
    b.fetch_ack = 1'b1;
    tick();
    b.fetch_ack = 1'b0;
    chk("werr sticky", b.wait_err, 1);
    drive(J, 16'h0000, 1'b1, 16'h0444, 16'h0000);
    tick();
    clr();
    chk("mid rv", b.redirect_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst rv", b.redirect_valid, 0);
    chk("arst pc", b.redirect_pc, 0);
    chk("arst flush", b.flush_if, 0);
    chk("arst stall", b.stall_id, 0);
    chk("arst err", b.wait_err, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    go("s1", BEQZ, 16'h0000, 16'h0010, 16'h0000, 1'b1, 16'h0010);
    go("s2", J, 16'h0000, 16'h0020, 16'h0000, 1'b1, 16'h0020);
    go("s3", JAL, 16'h0000, 16'h0030, 16'h0000, 1'b1, 16'h0030);
    go("s4", BNEZ, 16'h0000, 16'h0040, 16'h0000, 1'b0, 16'h0000);
    go("s5", BLTZ, 16'h0001, 16'h0050, 16'h0000, 1'b0, 16'h0000);
`ifdef BRJ_STATS_EN
    chk("brj_cnt", b.brj_cnt, 5);
    chk("taken_cnt", b.taken_cnt, 3);
`else
    chk("brj_cnt", b.brj_cnt, 0);
    chk("taken_cnt", b.taken_cnt, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
